// File: rtl/gate_occupancy_counter.sv
// Two-beam doorway counter: synchronise and debounce the beams, decode traversals, keep a saturating head count.
// Latency: raw beam change to filtered change 2+DEBOUNCE cycles, plus one registered cycle to the event pulses; no backpressure.
module gate_occupancy_counter #(
    parameter int CNT_W    = 8,
    parameter int MAX_OCC  = 200,
    parameter int DEBOUNCE = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       G,
    output logic [CNT_W-1:0] OCCUPANCY,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ENTRY_PULSE,
    output logic             EXIT_PULSE,
    output logic             SEQ_ERR,
    output logic             SAT
);

    localparam int                DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_OCC);

    typedef enum logic [2:0] {
        S_IDLE, S_IN1, S_IN2, S_IN3, S_OUT1, S_OUT2, S_OUT3, S_WAIT
    } state_t;

    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            f_q, f_d, f_prev_q, f_prev_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  entry_q, entry_d, exit_q, exit_d, err_q, err_d, sat_q, sat_d;
    logic                  f_chg, ev_entry, ev_exit, ev_err;

    always_comb begin
        sync1_d  = G;
        sync2_d  = sync1_q;
        f_prev_d = f_q;
        f_d      = f_q;
        db_cnt_d = '0;
        // The counter only runs while the synced bit disagrees with the filtered bit.
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != f_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    f_d[b] = ~f_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
        f_chg = (f_q != f_prev_q);
    end

    always_comb begin
        state_d = state_q;
        if (f_chg) begin
            case (state_q)
                S_IDLE: case (f_q)
                    2'b01:   state_d = S_IN1;
                    2'b10:   state_d = S_OUT1;
                    2'b11:   state_d = S_WAIT;
                    default: ;
                endcase
                S_IN1: case (f_q)
                    2'b00:   state_d = S_IDLE;
                    2'b11:   state_d = S_IN2;
                    default: state_d = S_WAIT;
                endcase
                S_IN2: case (f_q)
                    2'b10:   state_d = S_IN3;
                    2'b01:   state_d = S_IN1;
                    default: state_d = S_WAIT;
                endcase
                S_IN3: case (f_q)
                    2'b00:   state_d = S_IDLE;
                    2'b11:   state_d = S_IN2;
                    default: state_d = S_WAIT;
                endcase
                S_OUT1: case (f_q)
                    2'b00:   state_d = S_IDLE;
                    2'b11:   state_d = S_OUT2;
                    default: state_d = S_WAIT;
                endcase
                S_OUT2: case (f_q)
                    2'b01:   state_d = S_OUT3;
                    2'b10:   state_d = S_OUT1;
                    default: state_d = S_WAIT;
                endcase
                S_OUT3: case (f_q)
                    2'b00:   state_d = S_IDLE;
                    2'b11:   state_d = S_OUT2;
                    default: state_d = S_WAIT;
                endcase
                default: if (f_q == 2'b00) state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_entry = 1'b0;
        ev_exit  = 1'b0;
        ev_err   = 1'b0;
        if (f_chg) begin
            case (state_q)
                S_IDLE:  ev_err = (f_q == 2'b11);
                S_IN1:   ev_err = (f_q == 2'b10);
                S_IN2:   ev_err = (f_q == 2'b00);
                S_IN3: begin
                    ev_err   = (f_q == 2'b01);
                    ev_entry = (f_q == 2'b00);
                end
                S_OUT1:  ev_err = (f_q == 2'b01);
                S_OUT2:  ev_err = (f_q == 2'b00);
                S_OUT3: begin
                    ev_err  = (f_q == 2'b10);
                    ev_exit = (f_q == 2'b00);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        occ_d   = occ_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        sat_d   = 1'b0;
        err_d   = ev_err;
        if (ev_entry) begin
            if (occ_q < MAX_C) begin
                occ_d   = occ_q + 1'b1;
                entry_d = 1'b1;
            end else begin
                sat_d = 1'b1;
            end
        end
        if (ev_exit) begin
            if (occ_q != '0) begin
                occ_d  = occ_q - 1'b1;
                exit_d = 1'b1;
            end else begin
                sat_d = 1'b1;
            end
        end
        full_d  = (occ_d == MAX_C);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_cnt_q <= '0;
            f_q      <= '0;
            f_prev_q <= '0;
            state_q  <= S_IDLE;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_cnt_q <= db_cnt_d;
            f_q      <= f_d;
            f_prev_q <= f_prev_d;
            state_q  <= state_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            entry_q  <= entry_d;
            exit_q   <= exit_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
        end
    end

    assign OCCUPANCY   = occ_q;
    assign FULL        = full_q;
    assign EMPTY       = empty_q;
    assign ENTRY_PULSE = entry_q;
    assign EXIT_PULSE  = exit_q;
    assign SEQ_ERR     = err_q;
    assign SAT         = sat_q;

endmodule

// File: doc/gate_occupancy_counter.md
Name: gate_occupancy_counter

Overview:
Two-beam doorway sensor that counts people through a single gate instead of tracking two fixed identities. It debounces the raw beam inputs and decodes full traversals by direction. It maintains a saturating occupancy count and flags aborted, illegal and saturating events. It sits between the beam-sensor pins and the display/level logic of the sensor subsystem.

Parameters:
CNT_W, 8, width of OCCUPANCY.
MAX_OCC, 200, capacity at which FULL asserts. Must satisfy 1 <= MAX_OCC <= 2^CNT_W-1.
DEBOUNCE, 4, consecutive cycles a synchronised beam bit must hold a new value before it is accepted. Must be >= 1.

Ports:
CLK  input  1  system clock, all logic on posedge.
RESET  input  1  synchronous, active-high reset.
G  input  2  raw beam states, 1 = blocked. G[0] = outer beam, G[1] = inner beam. Asynchronous to CLK.
OCCUPANCY  output  CNT_W  current head count.
FULL  output  1  OCCUPANCY == MAX_OCC.
EMPTY  output  1  OCCUPANCY == 0.
ENTRY_PULSE  output  1  one-cycle pulse per counted entry.
EXIT_PULSE  output  1  one-cycle pulse per counted exit.
SEQ_ERR  output  1  one-cycle pulse on an illegal beam transition.
SAT  output  1  one-cycle pulse when a traversal completes but the count is blocked by FULL or EMPTY.

Behaviour:
- Reset (synchronous, active-high): applies on the posedge where RESET=1.
  - 2-flop synchronisers, filtered value F, debounce counters and FSM all clear (F=00, state IDLE).
  - OCCUPANCY=0, EMPTY=1, FULL=0, all pulses 0.
  - RESET wins over every simultaneous event.
- Input path, per bit:
  - 2-flop synchroniser, then debounce.
  - The debounce counter reloads when the synced bit equals F.
  - F bit flips once the synced bit has differed from F for DEBOUNCE consecutive cycles.
  - Latency from G change to F change = 2 + DEBOUNCE cycles. Glitches shorter than DEBOUNCE cycles are ignored.
- The FSM advances only on a change of F. With F unchanged, the state holds. Notation below is F = {inner, outer}.
  - IDLE: 01 -> IN1; 10 -> OUT1; 11 -> SEQ_ERR, go to WAIT.
  - IN1: 00 -> IDLE (abort, no count); 11 -> IN2; 10 -> SEQ_ERR, WAIT.
  - IN2: 10 -> IN3; 01 -> IN1 (backing out); 00 -> SEQ_ERR, WAIT.
  - IN3: 00 -> IDLE plus entry event; 11 -> IN2; 01 -> SEQ_ERR, WAIT.
  - OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with the bits swapped. OUT3 on 00 -> IDLE plus exit event.
  - WAIT: stay until F == 00, then go to IDLE with no count.
- Event resolution, registered in the cycle after F changes to 00:
  - Entry, OCCUPANCY < MAX_OCC: OCCUPANCY+1, ENTRY_PULSE=1.
  - Entry, FULL: no change, SAT=1, ENTRY_PULSE=0.
  - Exit, OCCUPANCY > 0: OCCUPANCY-1, EXIT_PULSE=1.
  - Exit, EMPTY: no change, SAT=1, EXIT_PULSE=0.
- FULL and EMPTY are registered alongside OCCUPANCY, so they update in the same cycle as the count. No wrap-around, ever.
- At most one event per cycle. Both bits of F changing in one cycle counts as one F change and is handled by the table above (e.g. IN1 seeing 10 is illegal).
- Reset mid-traversal: the count is unchanged by the partial traversal. After reset, beams still blocked are decoded from IDLE. Example: inner-only blocked gives OUT1, so a person finishing an entry produces SEQ_ERR or an abort, never a miscount.

Test Plan:
- Params 8/200/4, each phase held 10 cycles. Entry sequence G 00,01,11,10,00 -> ENTRY_PULSE once, exactly 2+4+1 = 7 cycles after the final 00 is applied; OCCUPANCY 0->1; EMPTY 1->0.
- Three entries then exit sequence G 00,10,11,01,00 -> EXIT_PULSE once, OCCUPANCY 3->2. Entry abort 00,01,00 -> no pulses, OCCUPANCY stays 2.
- Backing out 00,01,11,01,00 and a 3-cycle glitch on G[0] while idle -> no pulses, no SEQ_ERR, state returns to IDLE.
- Illegal jump 00->11 -> SEQ_ERR one cycle. Count is unchanged, and further changes are ignored until G=00. A following legal entry counts normally.
- MAX_OCC=2: three entries -> OCCUPANCY 2, FULL=1, third entry gives SAT=1 and no ENTRY_PULSE. From 0, one exit -> SAT=1, OCCUPANCY stays 0.
- RESET=1 for 1 cycle while in IN2 with OCCUPANCY=5 -> next cycle OCCUPANCY=0, EMPTY=1, all pulses 0. Releasing the beams via 10,00 counts nothing.
